// File: rtl/btb_update_ctrl_if.sv
// Retire-update, flush and BTB write-port signals for btb_update_ctrl.
// The master side is the ROB/BTB environment; the slave side is the controller.
interface btb_update_ctrl_if #(
    parameter int IDX_W = 10,
    parameter int TGT_W = 30
);
    logic              rob_retire_jump0;
    logic [63:0]       rob_retire_pc0;
    logic [63:0]       rob_cre_npc0;
    logic              rob_retire_jump1;
    logic [63:0]       rob_retire_pc1;
    logic [63:0]       rob_cre_npc1;
    logic              flush_req;
    logic              btb_wr_en;
    logic [IDX_W-1:0]  btb_wr_idx;
    logic [TGT_W-1:0]  btb_wr_data;
    logic              btb_wr_valid;
    logic              upd_stall;
    logic              busy;
    logic [15:0]       drop_cnt;

    modport master (
        output rob_retire_jump0, rob_retire_pc0, rob_cre_npc0,
        output rob_retire_jump1, rob_retire_pc1, rob_cre_npc1,
        output flush_req,
        input  btb_wr_en, btb_wr_idx, btb_wr_data, btb_wr_valid,
        input  upd_stall, busy, drop_cnt
    );

    modport slave (
        input  rob_retire_jump0, rob_retire_pc0, rob_cre_npc0,
        input  rob_retire_jump1, rob_retire_pc1, rob_cre_npc1,
        input  flush_req,
        output btb_wr_en, btb_wr_idx, btb_wr_data, btb_wr_valid,
        output upd_stall, busy, drop_cnt
    );
endinterface

// File: rtl/btb_update_ctrl.sv
// Owns the BTB write port: queues up to two retiring jump updates per cycle, drains one per
// cycle, and walks the whole array invalid after reset/flush. Optional: BTB_UPD_COALESCE_EN.
module btb_update_ctrl #(
    parameter int NUM_ENTRIES = 1024,
    parameter int IDX_W       = 10,
    parameter int TGT_W       = 30,
    parameter int QDEPTH      = 4,
    parameter int PTR_W       = 2
) (
    input logic              clock,
    input logic              reset,
    btb_update_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_walk_cnt, w_walk_nxt;
    logic [IDX_W-1:0] r_q_idx [QDEPTH];
    logic [TGT_W-1:0] r_q_dat [QDEPTH];
    logic [IDX_W-1:0] w_q_idx_nxt [QDEPTH];
    logic [TGT_W-1:0] w_q_dat_nxt [QDEPTH];
    logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [PTR_W:0]   r_count, w_count_nxt;
    logic [15:0]      r_drop_cnt;
    logic             r_stall;
    logic [1:0]       w_drops;
    logic             w_flush, w_pop, w_hit;
    logic             w_jmp   [2];
    logic [IDX_W-1:0] w_p_idx [2];
    logic [TGT_W-1:0] w_p_dat [2];
    logic             w_unused_bits;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_jmp[0]   = bus.rob_retire_jump0;
    assign w_jmp[1]   = bus.rob_retire_jump1;
    assign w_p_idx[0] = bus.rob_retire_pc0[IDX_W+1:2];
    assign w_p_idx[1] = bus.rob_retire_pc1[IDX_W+1:2];
    assign w_p_dat[0] = bus.rob_cre_npc0[TGT_W+1:2];
    assign w_p_dat[1] = bus.rob_cre_npc1[TGT_W+1:2];
    assign w_unused_bits = ^{bus.rob_retire_pc0[63:IDX_W+2], bus.rob_retire_pc0[1:0],
                             bus.rob_retire_pc1[63:IDX_W+2], bus.rob_retire_pc1[1:0],
                             bus.rob_cre_npc0[63:TGT_W+2], bus.rob_cre_npc0[1:0],
                             bus.rob_cre_npc1[63:TGT_W+2], bus.rob_cre_npc1[1:0]};

    // A flush in RUN suppresses this cycle's drain so no queued entry reaches the array.
    assign w_flush = (r_state == ST_RUN) && bus.flush_req;
    assign w_pop   = (r_state == ST_RUN) && (r_count != '0) && !bus.flush_req;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_walk_nxt       = r_walk_cnt;
        bus.btb_wr_en    = 1'b0;
        bus.btb_wr_idx   = '0;
        bus.btb_wr_data  = '0;
        bus.btb_wr_valid = 1'b0;
        bus.busy         = 1'b0;
        case (r_state)
            ST_INIT, ST_FLUSH: begin
                bus.btb_wr_en  = 1'b1;
                bus.btb_wr_idx = r_walk_cnt;
                bus.busy       = 1'b1;
                if (r_walk_cnt == IDX_W'(NUM_ENTRIES - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_walk_nxt  = '0;
                end else begin
                    w_walk_nxt = r_walk_cnt + IDX_W'(1);
                end
            end
            default: begin
                if (bus.flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_pop) begin
                    bus.btb_wr_en    = 1'b1;
                    bus.btb_wr_idx   = r_q_idx[r_head];
                    bus.btb_wr_data  = r_q_dat[r_head];
                    bus.btb_wr_valid = 1'b1;
                end
            end
        endcase
    end

    // Pushes see the queue after this cycle's pop; slot 0 is applied before slot 1.
    always_comb begin
        w_q_idx_nxt = r_q_idx;
        w_q_dat_nxt = r_q_dat;
        w_head_nxt  = r_head + PTR_W'(w_pop);
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count - (PTR_W+1)'(w_pop);
        w_drops     = '0;
        w_hit       = 1'b0;
        for (int s = 0; s < 2; s++) begin
            w_hit = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
            for (int k = 0; k < QDEPTH; k++) begin
                if (w_jmp[s] && !w_hit && ((PTR_W+1)'(k) < w_count_nxt) &&
                    (w_q_idx_nxt[w_head_nxt + PTR_W'(k)] == w_p_idx[s])) begin
                    w_q_dat_nxt[w_head_nxt + PTR_W'(k)] = w_p_dat[s];
                    w_hit = 1'b1;
                end
            end
`endif
            if (w_jmp[s] && !w_hit) begin
                if (w_count_nxt != (PTR_W+1)'(QDEPTH)) begin
                    w_q_idx_nxt[w_tail_nxt] = w_p_idx[s];
                    w_q_dat_nxt[w_tail_nxt] = w_p_dat[s];
                    w_tail_nxt  = w_tail_nxt + PTR_W'(1);
                    w_count_nxt = w_count_nxt + (PTR_W+1)'(1);
                end else begin
                    w_drops = w_drops + 2'd1;
                end
            end
        end
        if (w_flush) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
            w_drops     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_walk_cnt <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_walk_cnt <= w_walk_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_drop_cnt <= sat_add16(r_drop_cnt, w_drops);
            r_stall    <= (w_count_nxt > (PTR_W+1)'(QDEPTH - 2));
        end
    end

    always_ff @(posedge clock) begin
        r_q_idx <= w_q_idx_nxt;
        r_q_dat <= w_q_dat_nxt;
    end

    assign bus.upd_stall = r_stall;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: directed and random retire traffic against a
// queue-based reference of the BTB write stream and status outputs.
module tb_btb_update_ctrl;
    localparam int NE    = 1024;
    localparam int IDX_W = 10;
    localparam int TGT_W = 30;
    localparam int QD    = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    btb_update_ctrl_if #(.IDX_W(IDX_W), .TGT_W(TGT_W)) bus ();

    btb_update_ctrl #(
        .NUM_ENTRIES(NE), .IDX_W(IDX_W), .TGT_W(TGT_W), .QDEPTH(QD), .PTR_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct { logic [IDX_W-1:0] idx; logic [TGT_W-1:0] data; logic valid; } wr_t;
    typedef struct { logic [IDX_W-1:0] idx; logic [TGT_W-1:0] data; } ent_t;

    wr_t  exp_q[$];
    ent_t pend[$];
    int   checks   = 0;
    int   failures = 0;

    bit   m_en = 1'b0;
    bit   m_walk;
    int   m_walk_idx;
    int   m_drop;
    bit   m_stall;
    bit   cur_busy, cur_stall;
    int   cur_drop;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: one call per clock cycle with that cycle's inputs already applied.
    task automatic model_step();
        ent_t e;
        bit   hit;
        bit   j;
        logic [63:0] pc, npc;
        cur_busy  = m_walk;
        cur_stall = m_stall;
        cur_drop  = m_drop;
        if (m_walk) begin
            exp_q.push_back('{idx: IDX_W'(m_walk_idx), data: '0, valid: 1'b0});
            if (m_walk_idx == NE - 1) begin
                m_walk     = 1'b0;
                m_walk_idx = 0;
            end else begin
                m_walk_idx++;
            end
        end else if (bus.flush_req) begin
            pend.delete();
            m_walk     = 1'b1;
            m_walk_idx = 0;
            m_stall    = 1'b0;
            return;
        end else if (pend.size() > 0) begin
            e = pend.pop_front();
            exp_q.push_back('{idx: e.idx, data: e.data, valid: 1'b1});
        end
        for (int s = 0; s < 2; s++) begin
            j   = (s == 0) ? bus.rob_retire_jump0 : bus.rob_retire_jump1;
            pc  = (s == 0) ? bus.rob_retire_pc0   : bus.rob_retire_pc1;
            npc = (s == 0) ? bus.rob_cre_npc0     : bus.rob_cre_npc1;
            if (j) begin
                e.idx  = IDX_W'((pc >> 2) % NE);
                e.data = TGT_W'((npc >> 2) % (64'd1 << TGT_W));
                hit    = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
                foreach (pend[k]) begin
                    if (!hit && pend[k].idx == e.idx) begin
                        pend[k].data = e.data;
                        hit = 1'b1;
                    end
                end
`endif
                if (!hit) begin
                    if (pend.size() < QD) pend.push_back(e);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
        m_stall = (QD - pend.size()) < 2;
    endtask

    task automatic apply(input bit j0, input logic [63:0] pc0, input logic [63:0] npc0,
                         input bit j1, input logic [63:0] pc1, input logic [63:0] npc1,
                         input bit fl);
        bus.rob_retire_jump0 = j0;
        bus.rob_retire_pc0   = pc0;
        bus.rob_cre_npc0     = npc0;
        bus.rob_retire_jump1 = j1;
        bus.rob_retire_pc1   = pc1;
        bus.rob_cre_npc1     = npc1;
        bus.flush_req        = fl;
        if (m_en) model_step();
    endtask

    task automatic drive(input bit j0, input logic [63:0] pc0, input logic [63:0] npc0,
                         input bit j1, input logic [63:0] pc1, input logic [63:0] npc1,
                         input bit fl);
        @(posedge clock);
        #1;
        apply(j0, pc0, npc0, j1, pc1, npc1, fl);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [63:0] rnd_pc();
        return 64'(($urandom_range(0, 7) << 2) | (($urandom & 32'hFF) << 12));
    endfunction

    task automatic random_phase(input int n, input int flush_one_in);
        bit j0, j1, fl;
        for (int i = 0; i < n; i++) begin
            j0 = $urandom_range(0, 1) == 1;
            j1 = $urandom_range(0, 1) == 1;
            if (bus.upd_stall && $urandom_range(0, 3) != 0) begin
                j0 = 1'b0;
                j1 = 1'b0;
            end
            fl = (flush_one_in > 0) && ($urandom_range(1, flush_one_in) == 1);
            drive(j0, rnd_pc(), {$urandom, $urandom}, j1, rnd_pc(), {$urandom, $urandom}, fl);
        end
    endtask

    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clock);
            if (m_en) begin
                chk("busy", longint'(bus.busy), longint'(cur_busy));
                chk("upd_stall", longint'(bus.upd_stall), longint'(cur_stall));
                chk("drop_cnt", longint'(bus.drop_cnt), longint'(cur_drop));
                checks++;
                if (bus.btb_wr_en) begin
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL wr_unexpected actual idx=%0h data=%0h valid=%0b required none",
                                 bus.btb_wr_idx, bus.btb_wr_data, bus.btb_wr_valid);
                    end else begin
                        w = exp_q.pop_front();
                        if (bus.btb_wr_idx !== w.idx || bus.btb_wr_data !== w.data ||
                            bus.btb_wr_valid !== w.valid) begin
                            failures++;
                            $display("FAIL wr_entry actual idx=%0h data=%0h valid=%0b required idx=%0h data=%0h valid=%0b t=%0t",
                                     bus.btb_wr_idx, bus.btb_wr_data, bus.btb_wr_valid,
                                     w.idx, w.data, w.valid, $time);
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    failures++;
                    $display("FAIL wr_missing actual wr_en=0 required idx=%0h data=%0h valid=%0b t=%0t",
                             w.idx, w.data, w.valid, $time);
                end
            end
        end
    end

    initial begin
        bus.rob_retire_jump0 = 1'b0;
        bus.rob_retire_pc0   = '0;
        bus.rob_cre_npc0     = '0;
        bus.rob_retire_jump1 = 1'b0;
        bus.rob_retire_pc1   = '0;
        bus.rob_cre_npc1     = '0;
        bus.flush_req        = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset      = 1'b1;
        m_walk     = 1'b1;
        m_walk_idx = 0;
        m_drop     = 0;
        m_stall    = 1'b0;
        m_en       = 1'b1;
        apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

        // Five updates during the power-up walk: the fifth overflows the queue.
        drive(1'b1, 64'h200, 64'h1000, 1'b1, 64'h204, 64'h1004, 1'b0);
        drive(1'b1, 64'h208, 64'h1008, 1'b1, 64'h20C, 64'h100C, 1'b0);
        drive(1'b1, 64'h210, 64'h1010, 1'b0, '0, '0, 1'b0);
        idle(NE + 8);

        drive(1'b1, 64'h1010, 64'h2000, 1'b0, '0, '0, 1'b0);
        idle(3);
        drive(1'b1, 64'h100, 64'h200, 1'b1, 64'h104, 64'h300, 1'b0);
        idle(4);

        random_phase(400, 0);
        idle(6);

        // Three entries queued, then flush: none of them may be written.
        drive(1'b1, 64'h400, 64'h500, 1'b1, 64'h404, 64'h504, 1'b0);
        drive(1'b1, 64'h408, 64'h508, 1'b1, 64'h40C, 64'h50C, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

        // Same index twice during the walk, plus an ignored flush pulse.
        drive(1'b1, 64'h40, 64'h400, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 64'h40, 64'h800, 1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        idle(NE + 8);

        drive(1'b1, 64'h80, 64'h900, 1'b1, 64'h80, 64'hA00, 1'b0);
        idle(4);

        random_phase(2000, 700);
        idle(NE + 16);

        @(negedge clock);
        chk("exp_q_drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
